dmem_arbiter: RTL

- Shares the single-port data memory (`data_memory`) between two requesters: port 0 is the CPU load/store unit, port 1 is the debug/DMA loader.
- Accepts one request at a time over a valid/ready handshake and checks alignment and access mode.
- Drives the memory's wr_en/rw_mode/addr/w_data for exactly one cycle, then returns a one-cycle response to the owning port.

---
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: IDLE -> ACCESS -> RESP per request.
// Optional macro DMEM_ARB_FIXED_PRIO_EN: port 0 always wins a tie instead of round-robin.
module dmem_arbiter #(
  parameter int DMEM_DATA_WIDTH = 32,
  parameter int DMEM_ADDR_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_p0,
  input  logic                       req_valid_p1,
  output logic                       req_ready_p0,
  output logic                       req_ready_p1,
  input  logic                       req_we_p0,
  input  logic                       req_we_p1,
  input  logic [1:0]                 req_mode_p0,
  input  logic [1:0]                 req_mode_p1,
  input  logic [DMEM_ADDR_WIDTH-1:0] req_addr_p0,
  input  logic [DMEM_ADDR_WIDTH-1:0] req_addr_p1,
  input  logic [DMEM_DATA_WIDTH-1:0] req_wdata_p0,
  input  logic [DMEM_DATA_WIDTH-1:0] req_wdata_p1,
  output logic                       rsp_valid_p0,
  output logic                       rsp_valid_p1,
  output logic [DMEM_DATA_WIDTH-1:0] rsp_rdata,
  output logic                       rsp_err,
  output logic                       dmem_wr_en,
  output logic [1:0]                 dmem_rw_mode,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DMEM_DATA_WIDTH-1:0] dmem_w_data,
  input  logic [DMEM_DATA_WIDTH-1:0] dmem_r_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                     r_state, w_state_next;
  logic                       r_last_grant;
  logic                       r_owner;
  logic                       r_we;
  logic [1:0]                 r_mode;
  logic [DMEM_ADDR_WIDTH-1:0] r_addr;
  logic [DMEM_DATA_WIDTH-1:0] r_wdata;
  logic [DMEM_DATA_WIDTH-1:0] r_rdata;
  logic                       r_err;
  logic                       w_winner;
  logic                       w_accept;
  logic                       w_err;

  always_comb begin
    if (req_valid_p0 && !req_valid_p1) begin
      w_winner = 1'b0;
    end else if (!req_valid_p0 && req_valid_p1) begin
      w_winner = 1'b1;
    end else begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      w_winner = 1'b0;
`else
      w_winner = ~r_last_grant;
`endif
    end
  end

  always_comb begin
    case (r_mode)
      2'b00:   w_err = (r_addr[1:0] != 2'b00);
      2'b01:   w_err = r_addr[0];
      2'b10:   w_err = 1'b0;
      default: w_err = 1'b1;
    endcase
  end

  // Ready is gated by rst so every output reads 0 while reset is held.
  assign w_accept = rst && (r_state == S_IDLE) && (req_valid_p0 || req_valid_p1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready_p0 = 1'b0;
    req_ready_p1 = 1'b0;
    rsp_valid_p0 = 1'b0;
    rsp_valid_p1 = 1'b0;
    dmem_wr_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_p0 = rst && !w_winner && req_valid_p0;
        req_ready_p1 = rst && w_winner && req_valid_p1;
        if (w_accept) w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        dmem_wr_en   = r_we && !w_err;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid_p0 = !r_owner;
        rsp_valid_p1 = r_owner;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_mode       <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
        r_we         <= w_winner ? req_we_p1    : req_we_p0;
        r_mode       <= w_winner ? req_mode_p1  : req_mode_p0;
        r_addr       <= w_winner ? req_addr_p1  : req_addr_p0;
        r_wdata      <= w_winner ? req_wdata_p1 : req_wdata_p0;
      end
      if (r_state == S_ACCESS) begin
        r_rdata <= (r_we || w_err) ? '0 : dmem_r_data;
        r_err   <= w_err;
      end
    end
  end

  assign dmem_rw_mode = r_mode;
  assign dmem_addr    = r_addr;
  assign dmem_w_data  = r_wdata;
  assign rsp_rdata    = r_rdata;
  assign rsp_err      = r_err;

endmodule
